// File: rtl/md_sched_pkg.sv
// Shared encodings and timing defaults for the multiply/divide scheduler.
package md_sched_pkg;

  localparam logic [2:0] MdMult  = 3'd0;
  localparam logic [2:0] MdMultu = 3'd1;
  localparam logic [2:0] MdDiv   = 3'd2;
  localparam logic [2:0] MdDivu  = 3'd3;
  localparam logic [2:0] MdMthi  = 3'd4;
  localparam logic [2:0] MdMtlo  = 3'd5;

  localparam int unsigned MdMultCycles = 5;
  localparam int unsigned MdDivCycles  = 10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } md_state_e;

  // MULT/MULTU/DIV/DIVU occupy the low half of the encoding space.
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result generator; kept apart so an iterative divider can drop in later.
module md_calc
  import md_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    div0   = 1'b0;
    case (op)
      MdMult:  {res_hi, res_lo} = prod_s;
      MdMultu: {res_hi, res_lo} = prod_u;
      MdDiv: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          // Signed / and % truncate toward zero; remainder takes the dividend's sign.
          res_lo = $signed(a) / $signed(b);
          res_hi = $signed(a) % $signed(b);
        end
      end
      MdDivu: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MD scheduler: owns HI/LO, times operations and stalls colliding D-stage MD ops.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MdMultCycles,
  parameter int unsigned DIV_CYCLES  = MdDivCycles,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  input  logic        d_is_md,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        md_stall
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             div0_q, div0_d;
  logic [31:0]      calc_hi, calc_lo;
  logic             calc_div0;
  logic             start;

  md_calc u_calc (
    .op     (md_op),
    .a      (a),
    .b      (b),
    .res_hi (calc_hi),
    .res_lo (calc_lo),
    .div0   (calc_div0)
  );

  assign start    = op_valid && is_arith(md_op) && (state_q == StIdle);
  assign busy     = (state_q == StRun);
  assign md_stall = d_is_md && (busy || start);
  assign rd_data  = rd_sel ? hi_q : lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    div0_d   = div0_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          res_hi_d = calc_hi;
          res_lo_d = calc_lo;
          div0_d   = calc_div0;
          cnt_d    = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d  = StRun;
        end else if (op_valid && md_op == MdMthi) begin
          hi_d = a;
        end else if (op_valid && md_op == MdMtlo) begin
          lo_d = a;
        end
      end
      StRun: begin
        // Requests arriving here are ignored; the stall keeps a correct pipeline from sending any.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          if (!div0_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO queued at issue, checked when busy falls.
module tb_md_sched;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        d_is_md;
  logic [31:0] rd_data;
  logic        busy;
  logic        md_stall;

  int tests_run = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  md_sched dut (
    .clk      (clk),
    .reset    (rst_n),
    .op_valid (op_valid),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .rd_sel   (rd_sel),
    .d_is_md  (d_is_md),
    .rd_data  (rd_data),
    .busy     (busy),
    .md_stall (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op for a single cycle; returns at the first busy-cycle negedge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob,
                          input logic dmd, input logic [63:0] exp_hl, output logic stall_at_start);
    @(negedge clk);
    op_valid = 1'b1;
    md_op    = op;
    a        = oa;
    b        = ob;
    d_is_md  = dmd;
    exp_q.push_back(exp_hl);
    #1 stall_at_start = md_stall;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    rd_sel = 1'b1;
    #1 hi = rd_data;
    rd_sel = 1'b0;
    #1 lo = rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    rst_n = 1'b0; op_valid = 1'b1; md_op = 3'd0; a = 32'd5; b = 32'd7;
    rd_sel = 1'b0; d_is_md = 1'b1;
    #1;
    tests_run++;
    if (md_stall !== 1'b1) begin fails++; $display("FAIL reset_stall_start got %b want 1", md_stall); end
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    read_hl(hi, lo);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
    op_valid = 1'b0;
    #1;
    tests_run++;
    if (md_stall !== 1'b0) begin fails++; $display("FAIL reset_stall_idle got %b want 0", md_stall); end
    d_is_md = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult;
    logic [2:0]  ops [2] = '{3'd0, 3'd1};
    logic [63:0] exps[2] = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA};
    logic st;
    int n;
    logic [63:0] e;
    logic [31:0] hi, lo;
    for (int i = 0; i < 2; i++) begin
      start_op(ops[i], 32'hFFFFFFFE, 32'd3, 1'b0, exps[i], st);
      wait_done(n);
      tests_run++;
      if (n !== 5) begin fails++; $display("FAIL mult%0d_busy_cycles got %0d want 5", i, n); end
      e = exp_q.pop_front();
      read_hl(hi, lo);
      tests_run++;
      if ({hi, lo} !== e) begin fails++; $display("FAIL mult%0d_result got %h%h want %h", i, hi, lo, e); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [3] = '{3'd2, 3'd2, 3'd3};
    logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'd7, 32'd7};
    logic [31:0] bs  [3] = '{32'd2, 32'hFFFFFFFE, 32'd2};
    logic [63:0] exps[3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000001_00000003};
    logic st;
    int n;
    logic [63:0] e;
    logic [31:0] hi, lo;
    for (int i = 0; i < 3; i++) begin
      start_op(ops[i], as[i], bs[i], 1'b0, exps[i], st);
      wait_done(n);
      tests_run++;
      if (n !== 10) begin fails++; $display("FAIL div%0d_busy_cycles got %0d want 10", i, n); end
      e = exp_q.pop_front();
      read_hl(hi, lo);
      tests_run++;
      if ({hi, lo} !== e) begin fails++; $display("FAIL div%0d_result got %h%h want %h", i, hi, lo, e); end
    end
  endtask

  task automatic test_div0;
    logic st;
    int n;
    logic [63:0] e;
    logic [31:0] hi, lo;
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd4; a = 32'h1234; rd_sel = 1'b1;
    #1;
    tests_run++;
    if (rd_data !== 32'd1) begin fails++; $display("FAIL mthi_early got %h want 1", rd_data); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    tests_run++;
    if (rd_data !== 32'h1234 || busy !== 1'b0) begin
      fails++; $display("FAIL mthi_write got %h busy %b want 1234 busy 0", rd_data, busy);
    end
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd5; a = 32'h5678; rd_sel = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    tests_run++;
    if (rd_data !== 32'h5678 || busy !== 1'b0) begin
      fails++; $display("FAIL mtlo_write got %h busy %b want 5678 busy 0", rd_data, busy);
    end
    start_op(3'd3, 32'hFFFF, 32'd0, 1'b0, {32'h1234, 32'h5678}, st);
    wait_done(n);
    tests_run++;
    if (n !== 10) begin fails++; $display("FAIL div0_busy_cycles got %0d want 10", n); end
    e = exp_q.pop_front();
    read_hl(hi, lo);
    tests_run++;
    if ({hi, lo} !== e) begin fails++; $display("FAIL div0_unchanged got %h%h want %h", hi, lo, e); end
  endtask

  task automatic test_back_to_back;
    logic st;
    int n;
    int stall_bad;
    logic [63:0] e;
    logic [31:0] hi, lo;
    start_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFFA, st);
    tests_run++;
    if (st !== 1'b1) begin fails++; $display("FAIL b2b_stall_start got %b want 1", st); end
    n = 0;
    stall_bad = 0;
    while (busy === 1'b1 && n < 100) begin
      if (md_stall !== 1'b1) stall_bad++;
      if (n == 2) begin op_valid = 1'b1; md_op = 3'd4; a = 32'hDEADBEEF; end
      if (n == 3) op_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    tests_run++;
    if (n !== 5) begin fails++; $display("FAIL b2b_busy_cycles got %0d want 5", n); end
    tests_run++;
    if (stall_bad !== 0) begin fails++; $display("FAIL b2b_stall_run got %0d low cycles want 0", stall_bad); end
    #1;
    tests_run++;
    if (md_stall !== 1'b0) begin fails++; $display("FAIL b2b_stall_after got %b want 0", md_stall); end
    e = exp_q.pop_front();
    read_hl(hi, lo);
    tests_run++;
    if ({hi, lo} !== e) begin fails++; $display("FAIL b2b_result got %h%h want %h", hi, lo, e); end
    d_is_md = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic st;
    int n;
    int late;
    logic [31:0] hi, lo;
    start_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFD, st);
    n = 0;
    while (busy === 1'b1 && n < 2) begin
      n++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    read_hl(hi, lo);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL rstmid_hilo got %h/%h want 0/0", hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) late++;
    end
    read_hl(hi, lo);
    tests_run++;
    if (late !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
      fails++; $display("FAIL rstmid_late got busy %0d hilo %h/%h want 0 0/0", late, hi, lo);
    end
  endtask

  task automatic test_reserved;
    logic [2:0]  rops[2] = '{3'd6, 3'd7};
    logic [31:0] hi, lo;
    @(negedge clk);
    op_valid = 1'b1; md_op = 3'd4; a = 32'hA5A5;
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; md_op = rops[i]; a = 32'hFFFFFFFF; b = 32'd3; d_is_md = 1'b1;
      #1;
      tests_run++;
      if (md_stall !== 1'b0) begin fails++; $display("FAIL rsv%0d_stall got %b want 0", i, md_stall); end
      @(negedge clk);
      op_valid = 1'b0; d_is_md = 1'b0;
      tests_run++;
      if (busy !== 1'b0) begin fails++; $display("FAIL rsv%0d_busy got %b want 0", i, busy); end
      read_hl(hi, lo);
      tests_run++;
      if (hi !== 32'hA5A5 || lo !== 32'd0) begin
        fails++; $display("FAIL rsv%0d_hilo got %h/%h want 0000a5a5/0", i, hi, lo);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    test_reserved();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
